// File: rtl/decoder_pkg.sv
// Shared types for the index-decode/accumulate blocks: FSM state encoding and
// the default index width.
package decoder_pkg;

  localparam int CODE_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/decoder_3_8_accum_if.sv
// Bundle of the index-in / mask-out streams of decoder_3_8_accum.
// Handshake: a beat transfers on a rising clk edge where valid=1 and ready=1;
// valid never waits on ready, and a producer holds its payload while valid=1
// until the transfer happens.
interface decoder_3_8_accum_if
  import decoder_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  localparam int MASK_W = 2 ** CODE_W
);

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [MASK_W-1:0] out_mask;
  logic [CODE_W:0]   out_count;
  logic              out_dup;

  modport master (
    output in_valid, in_code, in_last, out_ready,
    input  in_ready, out_valid, out_mask, out_count, out_dup
  );

  modport slave (
    input  in_valid, in_code, in_last, out_ready,
    output in_ready, out_valid, out_mask, out_count, out_dup
  );

endinterface

// File: rtl/decoder_3_8.sv
// Combinational index decoder: CODE_W-bit code in, one-hot 2**CODE_W mask out.
module decoder_3_8
  import decoder_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  localparam int MASK_W = 2 ** CODE_W
) (
  input  logic [CODE_W-1:0] code,
  output logic [MASK_W-1:0] onehot
);

  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
  end

endmodule

// File: rtl/decoder_3_8_accum.sv
// Accumulates one-hot decodes of a packet of indices into a mask, then presents
// the mask, its popcount and a repeated-index flag until the consumer takes it.
module decoder_3_8_accum
  import decoder_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  localparam int MASK_W = 2 ** CODE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MASK_W-1:0] out_mask,
  output logic [CODE_W:0]   out_count,
  output logic              out_dup,
  output state_e            dbg_state
);

  state_e            state_q, state_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic              dup_q, dup_d;
  logic [MASK_W-1:0] out_mask_q, out_mask_d;
  logic [CODE_W:0]   out_count_q, out_count_d;
  logic              out_dup_q, out_dup_d;

  logic [MASK_W-1:0] onehot;
  logic [MASK_W-1:0] mask_next;
  logic              dup_next;
  logic [CODE_W:0]   pop_next;
  logic              accept;
  logic              consume;

  decoder_3_8 #(.CODE_W(CODE_W)) u_dec (
    .code   (in_code),
    .onehot (onehot)
  );

  assign accept  = in_valid & in_ready;
  assign consume = (state_q == HOLD) & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_last ? HOLD : ACCUM;
      ACCUM:   if (accept && in_last) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; in_ready is gated by rst_n so nothing is taken while in reset
  always_comb begin
    in_ready  = rst_n && (state_q != HOLD);
    out_valid = (state_q == HOLD);
    dbg_state = state_q;
  end

  // Candidate mask/flag including the current beat, plus its popcount
  always_comb begin
    mask_next = mask_q | onehot;
    dup_next  = dup_q | (|(mask_q & onehot));
    pop_next  = '0;
    for (int i = 0; i < MASK_W; i++) begin
      pop_next = pop_next + (CODE_W + 1)'(mask_next[i]);
    end
  end

  // The accumulator is emptied as soon as the last beat lands, so IDLE always
  // starts from a clean mask; the result lives only in the out_* registers.
  always_comb begin
    mask_d      = mask_q;
    dup_d       = dup_q;
    out_mask_d  = out_mask_q;
    out_count_d = out_count_q;
    out_dup_d   = out_dup_q;
    if (accept) begin
      if (in_last) begin
        mask_d      = '0;
        dup_d       = 1'b0;
        out_mask_d  = mask_next;
        out_count_d = pop_next;
        out_dup_d   = dup_next;
      end else begin
        mask_d = mask_next;
        dup_d  = dup_next;
      end
    end
    if (consume) begin
      out_mask_d  = '0;
      out_count_d = '0;
      out_dup_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q      <= '0;
      dup_q       <= 1'b0;
      out_mask_q  <= '0;
      out_count_q <= '0;
      out_dup_q   <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      dup_q       <= dup_d;
      out_mask_q  <= out_mask_d;
      out_count_q <= out_count_d;
      out_dup_q   <= out_dup_d;
    end
  end

  assign out_mask  = out_mask_q;
  assign out_count = out_count_q;
  assign out_dup   = out_dup_q;

endmodule

// File: tb/tb_decoder_3_8_accum.sv
// Randomized and directed packets for decoder_3_8_accum, checked by a
// negedge monitor against a set-based reference model.
module tb_decoder_3_8_accum;
  import decoder_pkg::*;

  localparam int W = 13;  // {mask[7:0], count[3:0], dup}

  logic   clk;
  logic   rst_n;
  state_e dbg_state;

  decoder_3_8_accum_if #(.CODE_W(3)) bus ();

  decoder_3_8_accum #(.CODE_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_code   (bus.in_code),
    .in_last   (bus.in_last),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_mask  (bus.out_mask),
    .out_count (bus.out_count),
    .out_dup   (bus.out_dup),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  int pkt[$];
  int ready_mode = 0;  // 0 random, 1 tied high, 2 held low
  int gap_max    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input int codes[$]);
    bit   seen[8];
    int   distinct = 0;
    bit   rep = 0;
    logic [7:0] m = '0;
    foreach (seen[i]) seen[i] = 0;
    foreach (codes[i]) begin
      if (seen[codes[i]]) rep = 1;
      else begin
        seen[codes[i]] = 1;
        distinct++;
        m[codes[i]] = 1'b1;
      end
    end
    return {m, distinct[3:0], rep};
  endfunction

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       bus.out_ready = 1'b1;
      2:       bus.out_ready = 1'b0;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic drive_beat(input int code, input bit last);
    bit done = 0;
    int gap;
    bus.in_valid = 1'b1;
    bus.in_code  = code[2:0];
    bus.in_last  = last;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL beat_timeout act=in_ready_low exp=accept code=%0d", code);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_code  = 3'($urandom);
    gap = $urandom_range(0, gap_max);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_packet();
    exp_q.push_back(model(pkt));
    foreach (pkt[i]) drive_beat(pkt[i], i == pkt.size() - 1);
  endtask

  task automatic wait_out_valid();
    bit seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    chk("out_valid_timeout", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit prev_fire_last = 0;
  bit prev_handshake = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("ready_in_reset", 32'(bus.in_ready), 32'd0);
      prev_fire_last = 0;
      prev_handshake = 0;
    end else begin
      if (prev_fire_last) chk("latency", 32'(bus.out_valid), 32'd1);
      if (prev_handshake) chk("one_pulse", 32'(bus.out_valid), 32'd0);
      chk("ready_vs_valid", 32'(bus.in_ready), 32'(!bus.out_valid));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out act=%0h exp=none", {bus.out_mask, bus.out_count, bus.out_dup});
        end else begin
          chk("result", 32'({bus.out_mask, bus.out_count, bus.out_dup}), 32'(exp_q[0]));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_zero", 32'({bus.out_mask, bus.out_count, bus.out_dup}), 32'd0);
      end
      prev_fire_last = bus.in_valid && bus.in_ready && bus.in_last;
      prev_handshake = bus.out_valid && bus.out_ready;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_code  = '0;
    bus.in_last  = 1'b0;
    bus.out_ready = 1'b0;
    ready_mode   = 1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    #1;

    // single beat code 5
    pkt = '{5};
    send_packet();
    // 0,3,7
    pkt = '{0, 3, 7};
    send_packet();
    // duplicate within packet
    pkt = '{2, 2, 4};
    send_packet();
    // duplicate on the last beat
    pkt = '{6, 1, 6};
    send_packet();

    // full mask, consumer stalls 5 cycles
    ready_mode = 2;
    pkt = '{0, 1, 2, 3, 4, 5, 6, 7};
    send_packet();
    wait_out_valid();
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    ready_mode = 1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("idle_after_full", 32'(dbg_state), 32'(IDLE));

    // reset mid-packet discards it
    drive_beat(1, 0);
    drive_beat(6, 0);
    pulse_reset();
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    pkt = '{0};
    send_packet();

    // reset while HOLD discards the pending result
    ready_mode = 2;
    pkt = '{3, 4};
    send_packet();
    wait_out_valid();
    pulse_reset();
    ready_mode = 1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end

    // back-to-back with out_ready tied high
    pkt = '{1};       send_packet();
    pkt = '{2, 3};    send_packet();
    pkt = '{7};       send_packet();
    pkt = '{4, 4, 4}; send_packet();

    // more than eight beats saturates the mask
    pkt = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 5, 7};
    send_packet();

    // random packets, random consumer and input gaps
    ready_mode = 0;
    gap_max    = 2;
    for (int p = 0; p < 40; p++) begin
      int len = $urandom_range(1, 12);
      pkt.delete();
      for (int b = 0; b < len; b++) pkt.push_back($urandom_range(0, 7));
      send_packet();
    end

    ready_mode = 1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_3_8_accum.md
DECODER_3_8_ACCUM -- requirements
Module: decoder_3_8_accum

Interface
REQ-001 SHALL have parameter CODE_W, default 3, meaning input index width.
REQ-002 SHALL have parameter MASK_W, default 2**CODE_W (8), meaning decoded mask width; MASK_W is derived and not overridden independently.
REQ-003 SHALL have port clk, input, 1, single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, an index beat is offered.
REQ-006 SHALL have port in_ready, output, 1, block accepts the index beat.
REQ-007 SHALL have port in_code, input, CODE_W, index to decode (0..7).
REQ-008 SHALL have port in_last, input, 1, the beat is the final index of a packet.
REQ-009 SHALL have port out_valid, output, 1, the accumulated mask is available.
REQ-010 SHALL have port out_ready, input, 1, the consumer takes the mask.
REQ-011 SHALL have port out_mask, output, MASK_W, OR of the one-hot decodes of all indices in the packet.
REQ-012 SHALL have port out_count, output, CODE_W+1, number of set bits in out_mask (0..8).
REQ-013 SHALL have port out_dup, output, 1, flag set when any index in the packet repeated.

Function
REQ-014 SHALL accept a beat only on a cycle where in_valid=1 and in_ready=1 at the rising clk edge.
REQ-015 SHALL implement states IDLE, ACCUM and HOLD.
REQ-016 SHALL, in IDLE, drive in_ready=1 with the internal mask at 0; an accepted non-last beat moves to ACCUM, and an accepted last beat moves to HOLD.
REQ-017 SHALL, in ACCUM, drive in_ready=1 and move to HOLD on an accepted beat with in_last=1; ACCUM stays in ACCUM while in_valid=0.
REQ-018 SHALL, in HOLD, drive out_valid=1 and in_ready=0; HOLD moves to IDLE on the edge where out_ready=1.
REQ-019 SHALL update the internal mask on every accepted beat to mask | (1 << in_code), so the last beat is included.
REQ-020 SHALL assert out_valid on the cycle immediately after the last beat is accepted (latency 1), with out_mask, out_count and out_dup valid on that same cycle.
REQ-021 SHALL hold out_mask, out_count and out_dup stable throughout HOLD regardless of in_valid.
REQ-022 SHALL register out_count, computed as popcount of the final mask; combinational popcount on the output is not permitted.
REQ-023 SHALL set the dup flag when an accepted code's bit is already set in the mask, including a duplicate within the last beat.
REQ-024 SHALL clear the dup flag when the packet is consumed.
REQ-025 SHALL drive out_mask, out_count and out_dup to 0 when out_valid=0.
REQ-026 SHALL allow a single-beat packet (in_last on the first beat), producing exactly one bit set and out_count=1.
REQ-027 SHALL, when all eight codes are received, produce out_mask=8'hFF and out_count=8 with no overflow.
REQ-028 SHALL allow more than eight beats per packet; the mask saturates by OR and out_dup=1.
REQ-029 SHALL, when out_ready is already 1 on entry to HOLD, hold out_valid for exactly one cycle, then return to IDLE and accept a new beat on the following cycle.

Reset
REQ-030 SHALL, while rst_n=0 at a clk edge, set the state to IDLE and clear the mask, dup flag, out_valid, out_mask, out_count and out_dup to 0.
REQ-031 SHALL drive in_ready=0 during reset cycles.
REQ-032 SHALL, on reset asserted mid-packet (ACCUM) or during HOLD, discard the partial or pending packet so that no out_valid occurs for it after reset release.
REQ-033 SHALL drive in_ready=1 on the first cycle after rst_n returns to 1.

Structure
REQ-034 SHALL place the state enum (IDLE, ACCUM, HOLD) and the CODE_W default in a shared package decoder_pkg.
REQ-035 SHALL instantiate a combinational sub-module decoder_3_8 (code in, one-hot out) for the index decode, reusable by other blocks.

Verification
REQ-036 SHALL cover the single beat code=5 with last=1, expecting out_valid on the next cycle, out_mask=8'h20, out_count=1 and out_dup=0.
REQ-037 SHALL cover codes 0,3,7 (last on 7), expecting out_mask=8'h89, out_count=3 and out_dup=0.
REQ-038 SHALL cover codes 2,2,4 with last, expecting out_mask=8'h14, out_count=2 and out_dup=1.
REQ-039 SHALL cover codes 0..7 with out_ready held 0 for 5 cycles, expecting out_mask=8'hFF and out_count=8 stable, in_ready=0 throughout HOLD, then IDLE one cycle after out_ready=1.
REQ-040 SHALL cover rst_n=0 for one cycle after codes 1,6 with no last, expecting no out_valid after release, and a following packet with code=0 and last giving out_mask=8'h01.
REQ-041 SHALL cover back-to-back packets with out_ready tied to 1, expecting each packet's out_valid as a one-cycle pulse and no leakage of mask bits between packets.
